// File: rtl/pipe_stage_skid_reg_if.sv
// pipe_stage_skid_reg_if: valid/ready handshake bundle carrying one PC and an opaque payload
interface pipe_stage_skid_reg_if #(
  parameter int PC_W      = 32,
  parameter int PAYLOAD_W = 161
);
  logic                 valid;
  logic                 ready;
  logic [PC_W-1:0]      pc;
  logic [PAYLOAD_W-1:0] payload;
  modport master (output valid, pc, payload, input ready);
  modport slave  (input valid, pc, payload, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline stage register with 2-entry skid buffer, flush with PC retention and bubble counter
module pipe_stage_skid_reg #(
  parameter int              PC_W      = 32,
  parameter int              PAYLOAD_W = 161,
  parameter logic [PC_W-1:0] PC_RESET  = 32'h0000_3000,
  parameter int              CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  pipe_stage_skid_reg_if.slave        in_if,
  pipe_stage_skid_reg_if.master       out_if,
  input  logic                        flush,
  input  logic                        flush_keep_pc,
  output logic [1:0]                  occupancy,
  output logic [CNT_W-1:0]            bubble_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t               state;
  logic [PC_W-1:0]      main_pc, skid_pc;
  logic [PAYLOAD_W-1:0] main_pl, skid_pl;
  logic                 out_valid, push, pop;
  assign out_valid      = state != EMPTY;
  assign occupancy      = state;
  assign in_if.ready    = (state != TWO) & ~flush;
  assign out_if.valid   = out_valid;
  assign out_if.pc      = main_pc;
  assign out_if.payload = out_valid ? main_pl : '0;
  assign push           = in_if.valid & in_if.ready;
  assign pop            = out_valid & out_if.ready;
  // Occupancy FSM: MAIN drives the outputs, SKID absorbs the one entry that arrives while MAIN is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      main_pc <= PC_RESET;
      main_pl <= '0;
      skid_pc <= '0;
      skid_pl <= '0;
    end else if (flush) begin
      state   <= EMPTY;
      main_pc <= flush_keep_pc ? main_pc : PC_RESET;
      main_pl <= '0;
      skid_pc <= '0;
      skid_pl <= '0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          main_pc <= in_if.pc;
          main_pl <= in_if.payload;
          state   <= ONE;
        end
        ONE: if (push && pop) begin
          main_pc <= in_if.pc;
          main_pl <= in_if.payload;
        end else if (push) begin
          skid_pc <= in_if.pc;
          skid_pl <= in_if.payload;
          state   <= TWO;
        end else if (pop) begin
          state   <= EMPTY;
        end
        TWO: if (pop) begin
          main_pc <= skid_pc;
          main_pl <= skid_pl;
          state   <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
  // Count edges that see an empty output, stopping at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bubble_cnt <= '0;
    else if (!out_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
  end
endmodule
